// File: rtl/serial_pattern_pkg.sv
// Shared types and default widths for the serial pattern transmitter.
package serial_pattern_pkg;

  localparam int unsigned PAT_WIDTH_DEF = 4;
  localparam int unsigned CNT_WIDTH_DEF = 4;

  // PARITY is only reachable when SERIAL_PATTERN_TX_PARITY_EN is defined
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } tx_state_t;

endpackage

// File: rtl/pat_bit_counter.sv
// Bit-position down-counter: load has priority, counts while enabled, flags index zero.
module pat_bit_counter #(
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [IDX_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             last_o
);

  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (load_i) begin
      idx_d = load_val_i;
    end else if (en_i && (idx_q != '0)) begin
      idx_d = idx_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign last_o = (idx_q == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// MSB-first serial pattern transmitter with repeat count, pause and done pulse.
// Define SERIAL_PATTERN_TX_PARITY_EN to append one even-parity bit per transfer.
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int unsigned PAT_WIDTH = PAT_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PAT_WIDTH-1:0] pattern,
  input  logic [CNT_WIDTH-1:0] repeat_cnt,
  input  logic                 pause,
  output logic                 o,
  output logic                 valid,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned IDX_W = $clog2(PAT_WIDTH);

  tx_state_t            state_q, state_d;
  logic [PAT_WIDTH-1:0] shift_q, shift_d;
  logic [PAT_WIDTH-1:0] hold_q, hold_d;
  logic [CNT_WIDTH-1:0] reps_q, reps_d;
  logic                 cnt_load;
  logic                 cnt_en;
  logic                 last_bit;

  pat_bit_counter #(
    .IDX_W (IDX_W)
  ) u_bit_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (IDX_W'(PAT_WIDTH - 1)),
    .en_i       (cnt_en),
    .last_o     (last_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      hold_q  <= '0;
      reps_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      reps_q  <= reps_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    hold_d   = hold_q;
    reps_d   = reps_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = pattern;
          hold_d  = pattern;
          reps_d  = repeat_cnt;
          if (repeat_cnt == '0) begin
            state_d = DONE;
          end else begin
            state_d  = SHIFT;
            cnt_load = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (!pause) begin
          cnt_en = 1'b1;
          if (!last_bit) begin
            shift_d = {shift_q[PAT_WIDTH-2:0], 1'b0};
          end else if (reps_q > CNT_WIDTH'(1)) begin
            // back-to-back reload: next repetition starts on the following cycle
            shift_d  = hold_q;
            reps_d   = reps_q - CNT_WIDTH'(1);
            cnt_load = 1'b1;
          end else begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = DONE;
`endif
          end
        end
      end
      PARITY: begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        if (!pause) begin
          state_d = DONE;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode directly from registered state
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  assign o     = (state_q == SHIFT)  ? shift_q[PAT_WIDTH-1] :
                 (state_q == PARITY) ? (^hold_q) : 1'b0;
  assign valid = ((state_q == SHIFT) || (state_q == PARITY)) && !pause;
`else
  assign o     = (state_q == SHIFT) ? shift_q[PAT_WIDTH-1] : 1'b0;
  assign valid = (state_q == SHIFT) && !pause;
`endif
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: directed and randomized transfers against a bit-queue model.
module tb_serial_pattern_tx;

  localparam int unsigned PW = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [PW-1:0] pattern;
  logic [CW-1:0] repeat_cnt;
  logic          pause;
  logic          o, valid, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  bit rx_q[$];

  serial_pattern_tx #(.PAT_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .pause      (pause),
    .o          (o),
    .valid      (valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic eo, input logic ev,
                          input logic eb, input logic ed);
    chk({tag, ".o"}, 32'(o), 32'(eo));
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  // Move to the next cycle: inputs change 1 time unit after the edge, outputs read 1 unit later
  task automatic next_cycle(input logic s, input logic p);
    @(posedge clk);
    #1;
    start = s;
    pause = p;
    #1;
  endtask

  // One complete transfer; the model is the flat list of bits the line must carry
  task automatic run_transfer(input logic [PW-1:0] pat, input logic [CW-1:0] reps,
                              input logic [31:0] pmask, input int pct,
                              input bit hold_start, output int cycles);
    bit exp_q[$];
    int ptr;
    int cyc;
    logic p;
    exp_q = {};
    for (int r = 0; r < int'(reps); r++)
      for (int b = PW - 1; b >= 0; b--) exp_q.push_back(pat[b]);
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    if (reps != 0) exp_q.push_back(^pat);
`endif
    rx_q = {};
    @(posedge clk);
    #1;
    start = 1'b1;
    pattern = pat;
    repeat_cnt = reps;
    pause = 1'($urandom);
    #1;
    chk("accept_idle.busy", 32'(busy), 32'd0);
    ptr = 0;
    cyc = 0;
    while (ptr < exp_q.size() && cyc < 2000) begin
      p = (cyc < 32) ? pmask[cyc] : 1'($urandom_range(99) < pct);
      @(posedge clk);
      #1;
      start = hold_start ? 1'b1 : 1'($urandom);
      pattern = PW'($urandom);
      repeat_cnt = CW'($urandom);
      pause = p;
      #1;
      chk_outs("bit", exp_q[ptr], !p, 1'b1, 1'b0);
      if (!p) begin
        rx_q.push_back(o);
        ptr++;
      end
      cyc++;
    end
    chk("timeout", 32'(cyc < 2000), 32'd1);
    cycles = cyc;
    next_cycle(hold_start ? 1'b1 : 1'($urandom), 1'($urandom));
    chk_outs("done_cycle", 1'b0, 1'b0, 1'b1, 1'b1);
    next_cycle(1'b0, 1'b0);
    chk_outs("back_idle", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int cycles;
    logic [15:0] hits;
    logic [11:0] stream;
    rst = 1'b1;
    start = 1'b0;
    pattern = '0;
    repeat_cnt = '0;
    pause = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single word 1101: four bits then done, then idle
    run_transfer(4'b1101, 4'd1, 32'd0, 0, 1'b0, cycles);
    chk("single.cycles", 32'(cycles), 32'd4);

    // three repetitions, no gaps; scan the received stream for 1101 endings
    run_transfer(4'b1101, 4'd3, 32'd0, 0, 1'b0, cycles);
    chk("rep3.cycles", 32'(cycles), 32'd12);
    stream = '0;
    hits = '0;
    for (int i = 0; i < rx_q.size() && i < 12; i++) begin
      stream = {stream[10:0], 1'(rx_q[i])};
      if (i >= 3 && stream[3:0] == 4'b1101) hits[i+1] = 1'b1;
    end
`ifndef SERIAL_PATTERN_TX_PARITY_EN
    chk("rep3.stream", 32'(stream), 32'hDDD);
    chk("rep3.hits", 32'(hits), 32'h1110);
`endif

    // pause for two cycles while the second bit is on the line
    run_transfer(4'b1011, 4'd1, 32'b0110, 0, 1'b0, cycles);
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    chk("pause.cycles", 32'(cycles), 32'd7);
`else
    chk("pause.cycles", 32'(cycles), 32'd6);
`endif

    // reset during the third bit of a two-word transfer
    next_cycle(1'b1, 1'b0);
    pattern = 4'b1011;
    repeat_cnt = 4'd2;
    chk("rst_mid.accept_busy", 32'(busy), 32'd0);
    next_cycle(1'b0, 1'b0);
    chk_outs("rst_mid.bit1", 1'b1, 1'b1, 1'b1, 1'b0);
    next_cycle(1'b0, 1'b0);
    chk_outs("rst_mid.bit2", 1'b0, 1'b1, 1'b1, 1'b0);
    next_cycle(1'b0, 1'b0);
    chk_outs("rst_mid.bit3", 1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    next_cycle(1'b0, 1'b0);
    rst = 1'b0;
    chk_outs("rst_mid.after", 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle(1'b0, 1'b0);
    chk_outs("rst_mid.no_done", 1'b0, 1'b0, 1'b0, 1'b0);
    run_transfer(4'b0110, 4'd1, 32'd0, 0, 1'b0, cycles);

    // zero repeats: straight to done, never valid
    run_transfer(4'b1111, 4'd0, 32'd0, 0, 1'b0, cycles);
    chk("zero.cycles", 32'(cycles), 32'd0);

    // start held high throughout: exactly one transfer
    run_transfer(4'b1001, 4'd2, 32'd0, 0, 1'b1, cycles);
    chk("held_start.cycles", 32'(cycles), 32'd8);

    // maximum repeat count
    run_transfer(4'b0101, 4'd15, 32'd0, 0, 1'b0, cycles);
    chk("max_reps.bits", 32'(rx_q.size()), 32'(PW * 15 + `ifdef SERIAL_PATTERN_TX_PARITY_EN 1 `else 0 `endif));

    // randomized transfers with random pauses and mid-transfer input noise
    for (int t = 0; t < 20; t++) begin
      run_transfer(PW'($urandom), CW'($urandom_range(0, 15)), $urandom, 30, 1'($urandom), cycles);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
